// File: rtl/pipelined_cpu8_pkg.sv
// pipelined_cpu8_pkg
// Shared definitions for the 8-bit three-stage CPU:
//   - data width and instruction memory depth
//   - opcode encoding (instruction bits [7:4]) and system sub-codes (bits [1:0])
//   - flag bit positions inside the packed flag vector
//   - reset PC, interrupt vector and the NOP encoding used for pipeline bubbles
//   - the EX/WB pipeline register layout and a flag-building helper
package pipelined_cpu8_pkg;

    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 256;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_MOV = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_NOT = 4'h6,
        OP_INC = 4'h7,
        OP_DEC = 4'h8,
        OP_OUT = 4'h9,
        OP_IN  = 4'hA,
        OP_JZ  = 4'hB,
        OP_JC  = 4'hC,
        OP_JMP = 4'hD,
        OP_LDI = 4'hE,
        OP_SYS = 4'hF
    } opcode_e;

    // Sub-codes carried in the rb field of OP_SYS; other values act as NOP.
    localparam logic [1:0] SYS_HLT = 2'b00;
    localparam logic [1:0] SYS_RTI = 2'b01;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_W = 3;

    localparam word_t RESET_PC   = 8'h00;
    localparam word_t INT_VECTOR = 8'hF0;
    localparam word_t NOP_INSTR  = 8'h00;

    // Result travelling from EX to the register-file write in WB.
    typedef struct packed {
        logic       valid;
        logic [1:0] dest;
        word_t      data;
    } exwb_t;

    // Build the packed flag vector from a result byte and a carry/borrow bit.
    function automatic logic [FLAG_W-1:0] make_flags(input word_t result, input logic carry);
        logic [FLAG_W-1:0] f;
        f         = 3'b000;
        f[FLAG_Z] = (result == 8'h00);
        f[FLAG_N] = result[7];
        f[FLAG_C] = carry;
        return f;
    endfunction

endpackage

// File: rtl/pipelined_cpu8_if.sv
// pipelined_cpu8_if
// System-side signal bundle of the CPU.
//   INTR_in   : level interrupt request, sampled on the rising clock edge
//   INPUT     : byte read by the IN instruction
//   OUTPUT    : registered byte written by the OUT instruction
//   load_*    : instruction-memory load port (write enable, address, data),
//               used to place a program in memory while the core is held in reset
// Modports: master = system/bench side, slave = CPU side.
interface pipelined_cpu8_if;
    import pipelined_cpu8_pkg::*;

    logic  INTR_in;
    word_t INPUT;
    word_t OUTPUT;
    logic  load_en;
    word_t load_addr;
    word_t load_data;

    modport master (
        output INTR_in,
        output INPUT,
        output load_en,
        output load_addr,
        output load_data,
        input  OUTPUT
    );

    modport slave (
        input  INTR_in,
        input  INPUT,
        input  load_en,
        input  load_addr,
        input  load_data,
        output OUTPUT
    );

endinterface

// File: rtl/instruction_memory.sv
// instruction_memory
// 256 x 8 instruction store with an asynchronous read port (used both for the
// fetch and for the LDI immediate, which always live at the same address) and
// a synchronous load port. Contents are not touched by the CPU reset.
//   clk      : clock for the load port
//   wr_en    : load strobe
//   wr_addr  : load address
//   wr_data  : load data
//   rd_addr  : read address (the current PC)
//   rd_data  : MEM[rd_addr], combinational
module instruction_memory
    import pipelined_cpu8_pkg::*;
(
    input  logic  clk,
    input  logic  wr_en,
    input  word_t wr_addr,
    input  word_t wr_data,
    input  word_t rd_addr,
    output word_t rd_data
);

    word_t MEM [0:MEM_DEPTH-1];

    // Program load port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            MEM[wr_addr] <= wr_data;
        end
    end

    assign rd_data = MEM[rd_addr];

endmodule

// File: rtl/pipelined_cpu8.sv
// pipelined_cpu8
// Three-stage (IF / EX / WB) 8-bit register CPU with four general registers,
// Z/N/C flags, one level-sensitive interrupt and a halt state.
//   CLK  : single clock, all state changes on the rising edge
//   RST  : synchronous active-high reset
//   bus  : system bundle (interrupt, input byte, registered output byte,
//          instruction-memory load port)
// IF latches MEM[PC] into IR and advances PC. EX decodes IR, updates flags,
// OUTPUT and control flow, and latches the register result into EX/WB. WB
// writes the register file; EX reads through a forward from EX/WB so no
// data stalls are needed.
module pipelined_cpu8
    import pipelined_cpu8_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    pipelined_cpu8_if.slave  bus
);

    word_t             pc_r;
    word_t             ir_r;
    word_t             out_r;
    word_t             epc_r;
    logic [3:0][7:0]   rf_r;
    logic [FLAG_W-1:0] flags_r;
    logic [FLAG_W-1:0] sflags_r;
    exwb_t             exwb_r;
    logic              busy_r;
    run_state_e        state_r;

    word_t             pc_next_s;
    word_t             ir_next_s;
    word_t             out_next_s;
    word_t             epc_next_s;
    logic [FLAG_W-1:0] flags_next_s;
    logic [FLAG_W-1:0] sflags_next_s;
    exwb_t             exwb_next_s;
    logic              busy_next_s;
    run_state_e        state_next_s;

    word_t             fetch_word_s;
    opcode_e           op_s;
    logic [1:0]        ra_s;
    logic [1:0]        rb_s;
    word_t             opa_s;
    word_t             opb_s;
    logic [8:0]        alu_s;
    logic              redirect_s;

    instruction_memory I_memory (
        .clk     (CLK),
        .wr_en   (bus.load_en),
        .wr_addr (bus.load_addr),
        .wr_data (bus.load_data),
        .rd_addr (pc_r),
        .rd_data (fetch_word_s)
    );

    assign op_s = opcode_e'(ir_r[7:4]);
    assign ra_s = ir_r[3:2];
    assign rb_s = ir_r[1:0];

    // The value about to be written in WB is newer than the register file.
    assign opa_s = (exwb_r.valid && (exwb_r.dest == ra_s)) ? exwb_r.data : rf_r[ra_s];
    assign opb_s = (exwb_r.valid && (exwb_r.dest == rb_s)) ? exwb_r.data : rf_r[rb_s];

    assign bus.OUTPUT = out_r;

    // Execute stage: decode, ALU, control-flow redirects, halt and interrupt entry.
    always_comb begin
        pc_next_s     = pc_r + 8'h01;
        ir_next_s     = fetch_word_s;
        out_next_s    = out_r;
        epc_next_s    = epc_r;
        flags_next_s  = flags_r;
        sflags_next_s = sflags_r;
        exwb_next_s   = '{valid: 1'b0, dest: 2'b00, data: 8'h00};
        busy_next_s   = busy_r;
        state_next_s  = state_r;
        alu_s         = 9'h000;
        redirect_s    = 1'b0;

        case (op_s)
            OP_NOP: begin
            end
            OP_MOV: begin
                exwb_next_s = '{valid: 1'b1, dest: ra_s, data: opb_s};
            end
            OP_ADD: begin
                alu_s        = {1'b0, opa_s} + {1'b0, opb_s};
                exwb_next_s  = '{valid: 1'b1, dest: ra_s, data: alu_s[7:0]};
                flags_next_s = make_flags(alu_s[7:0], alu_s[8]);
            end
            OP_SUB: begin
                // Bit 8 of the 9-bit difference is the borrow.
                alu_s        = {1'b0, opa_s} - {1'b0, opb_s};
                exwb_next_s  = '{valid: 1'b1, dest: ra_s, data: alu_s[7:0]};
                flags_next_s = make_flags(alu_s[7:0], alu_s[8]);
            end
            OP_AND: begin
                alu_s        = {1'b0, opa_s & opb_s};
                exwb_next_s  = '{valid: 1'b1, dest: ra_s, data: alu_s[7:0]};
                flags_next_s = make_flags(alu_s[7:0], flags_r[FLAG_C]);
            end
            OP_OR: begin
                alu_s        = {1'b0, opa_s | opb_s};
                exwb_next_s  = '{valid: 1'b1, dest: ra_s, data: alu_s[7:0]};
                flags_next_s = make_flags(alu_s[7:0], flags_r[FLAG_C]);
            end
            OP_NOT: begin
                exwb_next_s = '{valid: 1'b1, dest: ra_s, data: ~opa_s};
            end
            OP_INC: begin
                alu_s        = {1'b0, opa_s} + 9'h001;
                exwb_next_s  = '{valid: 1'b1, dest: ra_s, data: alu_s[7:0]};
                flags_next_s = make_flags(alu_s[7:0], alu_s[8]);
            end
            OP_DEC: begin
                alu_s        = {1'b0, opa_s} - 9'h001;
                exwb_next_s  = '{valid: 1'b1, dest: ra_s, data: alu_s[7:0]};
                flags_next_s = make_flags(alu_s[7:0], alu_s[8]);
            end
            OP_OUT: begin
                out_next_s = opb_s;
            end
            OP_IN: begin
                exwb_next_s = '{valid: 1'b1, dest: rb_s, data: bus.INPUT};
            end
            OP_JZ: begin
                if (flags_r[FLAG_Z]) begin
                    pc_next_s  = opb_s;
                    ir_next_s  = NOP_INSTR;
                    redirect_s = 1'b1;
                end else begin
                    redirect_s = 1'b0;
                end
            end
            OP_JC: begin
                if (flags_r[FLAG_C]) begin
                    pc_next_s  = opb_s;
                    ir_next_s  = NOP_INSTR;
                    redirect_s = 1'b1;
                end else begin
                    redirect_s = 1'b0;
                end
            end
            OP_JMP: begin
                pc_next_s  = opb_s;
                ir_next_s  = NOP_INSTR;
                redirect_s = 1'b1;
            end
            OP_LDI: begin
                // PC already points at the immediate: consume it instead of decoding it.
                exwb_next_s = '{valid: 1'b1, dest: ra_s, data: fetch_word_s};
                ir_next_s   = NOP_INSTR;
                redirect_s  = 1'b1;
            end
            OP_SYS: begin
                case (rb_s)
                    SYS_HLT: begin
                        state_next_s = ST_HALT;
                    end
                    SYS_RTI: begin
                        pc_next_s    = epc_r;
                        ir_next_s    = NOP_INSTR;
                        flags_next_s = sflags_r;
                        busy_next_s  = 1'b0;
                        redirect_s   = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
            end
        endcase

        // Halted (or halting now): PC holds, only bubbles enter IR.
        if (state_next_s == ST_HALT) begin
            pc_next_s = pc_r;
            ir_next_s = NOP_INSTR;
        end else begin
            ir_next_s = ir_next_s;
        end

        // The instruction in EX still completes; the one being fetched is
        // discarded and becomes the return address. The saved flags include
        // the effect of the completing instruction.
        if (bus.INTR_in && !busy_r && !redirect_s) begin
            epc_next_s    = pc_r;
            sflags_next_s = flags_next_s;
            pc_next_s     = INT_VECTOR;
            ir_next_s     = NOP_INSTR;
            busy_next_s   = 1'b1;
            state_next_s  = ST_RUN;
        end else begin
            busy_next_s = busy_next_s;
        end
    end

    // Run/halt state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Pipeline, architectural state and register-file write-back.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_r     <= RESET_PC;
            ir_r     <= NOP_INSTR;
            out_r    <= 8'h00;
            epc_r    <= 8'h00;
            rf_r     <= 32'h0000_0000;
            flags_r  <= 3'b000;
            sflags_r <= 3'b000;
            exwb_r   <= '{valid: 1'b0, dest: 2'b00, data: 8'h00};
            busy_r   <= 1'b0;
        end else begin
            pc_r     <= pc_next_s;
            ir_r     <= ir_next_s;
            out_r    <= out_next_s;
            epc_r    <= epc_next_s;
            flags_r  <= flags_next_s;
            sflags_r <= sflags_next_s;
            exwb_r   <= exwb_next_s;
            busy_r   <= busy_next_s;
            if (exwb_r.valid) begin
                rf_r[exwb_r.dest] <= exwb_r.data;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cpu8.sv
// tb_pipelined_cpu8
// Directed programs from the CPU's test plan plus random programs with random
// input bytes, interrupt pulses and occasional resets. Expected values come
// from an instruction-level interpreter: architectural registers update at
// once, and each clock either executes the held instruction word or fetches.
module tb_pipelined_cpu8;
    import pipelined_cpu8_pkg::*;

    logic CLK;
    logic RST;

    pipelined_cpu8_if bus ();

    pipelined_cpu8 dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference machine state.
    logic [7:0] m_mem [0:255];
    logic [7:0] m_r   [0:3];
    logic [7:0] m_pc, m_ir, m_out, m_epc;
    logic       m_z, m_n, m_c, m_sz, m_sn, m_sc, m_busy, m_halt;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: observed %02h expected %02h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 8'h00; m_ir = 8'h00; m_out = 8'h00; m_epc = 8'h00;
        for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
        m_z = 1'b0; m_n = 1'b0; m_c = 1'b0;
        m_sz = 1'b0; m_sn = 1'b0; m_sc = 1'b0;
        m_busy = 1'b0; m_halt = 1'b0;
    endtask

    task automatic set_zn(input int v);
        m_z = (v == 0);
        m_n = (v >= 128);
    endtask

    // One clock of the instruction-level machine.
    task automatic model_step(input logic intr, input logic [7:0] din);
        int op, ra, rb, a, b, res;
        logic [7:0] npc, nir;
        bit blocked;
        op  = int'(m_ir[7:4]);
        ra  = int'(m_ir[3:2]);
        rb  = int'(m_ir[1:0]);
        a   = int'(m_r[ra]);
        b   = int'(m_r[rb]);
        npc = m_pc + 8'd1;
        nir = m_mem[m_pc];
        blocked = 1'b0;
        res = 0;
        case (op)
            1:  m_r[ra] = b[7:0];
            2:  begin res = a + b; m_c = (res > 255); res = res % 256; set_zn(res); m_r[ra] = res[7:0]; end
            3:  begin m_c = (a < b); res = (a - b + 256) % 256; set_zn(res); m_r[ra] = res[7:0]; end
            4:  begin res = a & b; set_zn(res); m_r[ra] = res[7:0]; end
            5:  begin res = a | b; set_zn(res); m_r[ra] = res[7:0]; end
            6:  begin res = 255 - a; m_r[ra] = res[7:0]; end
            7:  begin m_c = (a == 255); res = (a + 1) % 256; set_zn(res); m_r[ra] = res[7:0]; end
            8:  begin m_c = (a == 0); res = (a + 255) % 256; set_zn(res); m_r[ra] = res[7:0]; end
            9:  m_out = b[7:0];
            10: m_r[rb] = din;
            11: if (m_z) begin npc = b[7:0]; nir = 8'h00; blocked = 1'b1; end
            12: if (m_c) begin npc = b[7:0]; nir = 8'h00; blocked = 1'b1; end
            13: begin npc = b[7:0]; nir = 8'h00; blocked = 1'b1; end
            14: begin m_r[ra] = m_mem[m_pc]; nir = 8'h00; blocked = 1'b1; end
            15: begin
                if (rb == 0) begin
                    m_halt = 1'b1;
                end else if (rb == 1) begin
                    npc = m_epc; nir = 8'h00; blocked = 1'b1;
                    m_z = m_sz; m_n = m_sn; m_c = m_sc; m_busy = 1'b0;
                end
            end
            default: begin end
        endcase
        if (m_halt) begin
            npc = m_pc;
            nir = 8'h00;
        end
        if (intr && !m_busy && !blocked) begin
            m_epc = m_pc;
            m_sz = m_z; m_sn = m_n; m_sc = m_c;
            npc = 8'hF0; nir = 8'h00;
            m_busy = 1'b1; m_halt = 1'b0;
        end
        m_pc = npc;
        m_ir = nir;
    endtask

    // Apply one clock with the given inputs, advance the model, compare.
    task automatic tick(input logic rst, input logic intr, input logic [7:0] din);
        logic [7:0] exp_f;
        RST = rst;
        bus.INTR_in = intr;
        bus.INPUT = din;
        @(posedge CLK);
        if (rst) model_reset();
        else model_step(intr, din);
        #1;
        exp_f = 8'h00;
        exp_f[FLAG_Z] = m_z;
        exp_f[FLAG_N] = m_n;
        exp_f[FLAG_C] = m_c;
        check_eq("output", bus.OUTPUT, m_out);
        check_eq("pc", dut.pc_r, m_pc);
        check_eq("ir", dut.ir_r, m_ir);
        check_eq("flags", {5'b00000, dut.flags_r}, exp_f);
        check_eq("busy", {7'b0000000, dut.busy_r}, {7'b0000000, m_busy});
    endtask

    task automatic run(input int n, input logic [7:0] din);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, din);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    endtask

    // Write m_mem into the DUT while held in reset, then two checked reset cycles.
    task automatic load_image();
        RST = 1'b1;
        bus.INTR_in = 1'b0;
        for (int i = 0; i < 256; i++) begin
            bus.load_en = 1'b1;
            bus.load_addr = i[7:0];
            bus.load_data = m_mem[i];
            @(posedge CLK);
            #1;
        end
        bus.load_en = 1'b0;
        model_reset();
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        RST = 1'b1;
        bus.INTR_in = 1'b0;
        bus.INPUT = 8'h00;
        bus.load_en = 1'b0;
        bus.load_addr = 8'h00;
        bus.load_data = 8'h00;
        model_reset();

        // All-NOP memory: PC counts up, OUTPUT stays 00.
        clear_mem();
        load_image();
        check_eq("rst_pc", dut.pc_r, 8'h00);
        check_eq("rst_out", bus.OUTPUT, 8'h00);
        run(10, 8'h00);
        check_eq("nop_pc", dut.pc_r, 8'h0A);

        // LDI R0,05; LDI R1,03; ADD R0,R1; OUT R0.
        clear_mem();
        m_mem[0] = 8'hE0; m_mem[1] = 8'h05; m_mem[2] = 8'hE4; m_mem[3] = 8'h03;
        m_mem[4] = 8'h21; m_mem[5] = 8'h90;
        load_image();
        run(12, 8'h00);
        check_eq("add_out", bus.OUTPUT, 8'h08);

        // LDI R2,10; LDI R0,FF; INC R0; JC R2; OUT R2 (skipped); at 10: LDI R1,3C; OUT R1.
        clear_mem();
        m_mem[0] = 8'hE8; m_mem[1] = 8'h10; m_mem[2] = 8'hE0; m_mem[3] = 8'hFF;
        m_mem[4] = 8'h70; m_mem[5] = 8'hC2; m_mem[6] = 8'h92;
        m_mem[16] = 8'hE4; m_mem[17] = 8'h3C; m_mem[18] = 8'h91;
        load_image();
        run(6, 8'h00);
        check_eq("jc_flags", {5'b00000, dut.flags_r}, 8'h05);
        run(14, 8'h00);
        check_eq("jc_out", bus.OUTPUT, 8'h3C);

        // IN R3; NOT R3; OUT R3 with INPUT=A5.
        clear_mem();
        m_mem[0] = 8'hA3; m_mem[1] = 8'h6C; m_mem[2] = 8'h93;
        load_image();
        run(8, 8'hA5);
        check_eq("not_out", bus.OUTPUT, 8'h5A);

        // Loop with interrupt; ISR at F0: LDI R1,77; OUT R1; RTI.
        clear_mem();
        m_mem[0] = 8'hEC; m_mem[1] = 8'h02; m_mem[2] = 8'h70; m_mem[3] = 8'hD3;
        m_mem[240] = 8'hE4; m_mem[241] = 8'h77; m_mem[242] = 8'h91; m_mem[243] = 8'hF1;
        load_image();
        run(9, 8'h00);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'h00);
        run(25, 8'h00);
        check_eq("isr_out", bus.OUTPUT, 8'h77);
        check_eq("isr_busy", {7'b0000000, dut.busy_r}, 8'h00);

        // LDI R0,42; OUT R0; HLT; then reset in the middle of the halt.
        clear_mem();
        m_mem[0] = 8'hE0; m_mem[1] = 8'h42; m_mem[2] = 8'h90; m_mem[3] = 8'hF0;
        load_image();
        run(10, 8'h00);
        check_eq("halt_pc", dut.pc_r, 8'h04);
        check_eq("halt_out", bus.OUTPUT, 8'h42);
        tick(1'b1, 1'b0, 8'h00);
        check_eq("halt_rst_out", bus.OUTPUT, 8'h00);
        check_eq("halt_rst_pc", dut.pc_r, 8'h00);
        run(3, 8'h00);
        check_eq("resume_pc", dut.pc_r, 8'h03);

        // Random programs, inputs, interrupt pulses and occasional resets.
        for (int p = 0; p < 15; p++) begin
            for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom_range(0, 255));
            load_image();
            for (int c = 0; c < 400; c++) begin
                tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) == 0),
                     8'($urandom_range(0, 255)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_cpu8.md
# pipelined_cpu8

8-bit, three-stage (IF/EX/WB) pipelined accumulator-free register CPU with a 256-byte instruction memory, a byte input port, a registered byte output port and one external interrupt. It is the top of the processor and the only block instantiated by system benches. The instruction memory is an internal instance named `I_memory` holding array `MEM [0:255]` of 8-bit words; benches load it hierarchically with `$readmemb`.

## Interface
- No parameters; memory depth is fixed at 256 and data width at 8.
- CLK  input  1  single clock; all state updates on rising edge.
- RST  input  1  reset, synchronous and active-high.
- INTR_in  input  1  interrupt request, level; sampled on rising edge.
- INPUT  input  8  data read by IN.
- OUTPUT  output  8  registered; written by OUT; resets to 8'h00.

## Operation
- State: PC[7:0], R0–R3 [7:0], flags Z, N, C, IR (IF/EX), EX/WB result register, EPC[7:0] and saved flags, IE-busy bit, halt bit.
- Encoding: [7:4] opcode, [3:2] ra, [1:0] rb.
- 0 NOP. 1 MOV ra←rb. 2 ADD ra←ra+rb (Z,N,C). 3 SUB ra←ra−rb (C = borrow). 4 AND, 5 OR (Z,N; C kept). 6 NOT ra←~ra. 7 INC ra, 8 DEC ra (Z,N,C). 9 OUT OUTPUT←R[rb]. A IN R[rb]←INPUT. B JZ PC←R[rb] if Z. C JC PC←R[rb] if C. D JMP PC←R[rb]. E LDI ra←next byte (2-byte instruction). F with rb=00 HLT, rb=01 RTI, others NOP.
- Arithmetic mod 256; Z = result==0, N = result[7].
- Memory contents initialise to 8'h00 (NOP) and are not affected by RST.
- Interrupt: when INTR_in=1, not already in service, and the EX instruction is not taken-branch/LDI/RTI, on that edge EPC←address of instruction that would execute next, flags saved, PC←8'hF0, IR flushed to NOP, busy set. RTI restores PC←EPC, flags, clears busy. Interrupt also clears halt. Nested interrupts ignored while busy.
- HLT: PC and IR freeze (IR holds NOP) until RST or interrupt.

## Timing
- Reset (RST=1 at edge): PC=0, IR=NOP, R0–R3=0, flags=0, OUTPUT=0, EPC=0, busy=0, halt=0, EX/WB invalid. Reset overrides interrupt and everything mid-operation.
- Edge k: IR←MEM[PC], PC←PC+1. Edge k+1: instruction executes; EX/WB and flags latched; OUTPUT updated for OUT. Edge k+2: register file written.
- Forwarding: EX/WB result forwards to EX operands; no data stalls.
- Taken branch resolved in EX: one bubble (IR←NOP), PC←target. Untaken: no penalty.
- LDI: byte fetched after LDI is consumed as immediate, never decoded.
- Simultaneous write and read of same register in one cycle returns new value (forwarding).
- PC wraps 8'hFF→8'h00.

## Structure
- Shared package: opcode constants, flag bit indices, reset PC (8'h00), interrupt vector (8'hF0), NOP encoding.
- Sub-module `instruction_memory` (instance `I_memory`, array `MEM`), asynchronous read. Register file and ALU may stay inline.

## Test plan
- RST=1 two cycles, release, all-NOP memory -> OUTPUT=00, PC increments 0,1,2….
- LDI R0,8'h05; LDI R1,8'h03; ADD R0,R1; OUT R0 -> OUTPUT=8'h08 on edge after OUT executes; back-to-back forwarding exercised.
- LDI R0,FF; INC R0; JC via R2=10 -> Z=1,C=1, PC=10, one bubble, instruction after JC never executes.
- INPUT=8'hA5; IN R3; NOT R3; OUT R3 -> OUTPUT=8'h5A.
- INTR_in pulse during a loop; ISR at F0 does OUT of 8'h77 then RTI -> OUTPUT=77, return to interrupted address, flags preserved.
- HLT then RST=1 mid-halt -> all state returns to reset values, fetch resumes at 0.
